// File: rtl/ab_tx_pkg.sv
// Shared types and constants for the a/b stimulus transmitter.
package ab_tx_pkg;

  typedef enum logic [1:0] {StIdle, StSend, StDrain, StDone} ab_tx_state_t;

  typedef struct packed {
    logic a;
    logic b;
  } ab_sym_t;

  localparam logic [7:0] HIT_MAX = 8'd255;

endpackage

// File: rtl/ab_sym_fifo.sv
// Small symbol FIFO; pointers carry one extra wrap bit to tell full from empty.
module ab_sym_fifo
  import ab_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  ab_sym_t din_i,
  input  logic    pop_i,
  input  logic    flush_i,
  output logic    full_o,
  output logic    empty_o,
  output logic    last_o,
  output ab_sym_t head_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  ab_sym_t     mem_q [DEPTH];
  logic        push_ok, pop_ok;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign last_o  = ((wr_q - rd_q) == (AW+1)'(1));
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // Fullness is judged before any pop in the same cycle.
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ab_stim_tx.sv
// Streams buffered a/b symbols to a sequence recognizer and counts its y detections.
module ab_stim_tx
  import ab_tx_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned DRAIN   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       wr_a,
  input  logic       wr_b,
  output logic       full,
  input  logic       go,
  output logic       a,
  output logic       b,
  output logic       sym_valid,
  input  logic       sym_ready,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [7:0] hit_cnt,
  output logic       err_timeout
);

  localparam int unsigned DrainW = $clog2(DRAIN + 1);

  ab_tx_state_t      state_q, state_d;
  logic [7:0]        stall_q, stall_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [7:0]        hit_q, hit_d;
  logic              err_q, err_d;

  logic    fifo_pop, fifo_flush, fifo_full, fifo_empty, fifo_last, push_ok;
  ab_sym_t fifo_head, fifo_din;

  assign fifo_din = '{a: wr_a, b: wr_b};
  assign push_ok  = wr_en & ~fifo_full;

  ab_sym_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (wr_en),
    .din_i  (fifo_din),
    .pop_i  (fifo_pop),
    .flush_i(fifo_flush),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .last_o (fifo_last),
    .head_o (fifo_head)
  );

  always_comb begin
    state_d    = state_q;
    stall_d    = stall_q;
    drain_d    = drain_q;
    hit_d      = hit_q;
    err_d      = err_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    if ((state_q == StSend || state_q == StDrain) && y && (hit_q != HIT_MAX)) begin
      hit_d = hit_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (go && !fifo_empty) begin
          state_d = StSend;
          hit_d   = '0;
          err_d   = 1'b0;
          stall_d = '0;
        end
      end
      StSend: begin
        if (sym_ready) begin
          fifo_pop = 1'b1;
          stall_d  = '0;
          // A push landing with the final pop keeps the run going.
          if (fifo_last && !push_ok) begin
            state_d = StDrain;
            drain_d = '0;
          end
        end else if (stall_q == 8'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          fifo_flush = 1'b1;
          stall_d    = '0;
          state_d    = StDone;
        end else begin
          stall_d = stall_q + 8'd1;
        end
      end
      StDrain: begin
        if (drain_q == DrainW'(DRAIN - 1)) state_d = StDone;
        else drain_d = drain_q + 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      stall_q <= '0;
      drain_q <= '0;
      hit_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      drain_q <= drain_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
    end
  end

  assign sym_valid   = (state_q == StSend);
  assign a           = sym_valid & fifo_head.a;
  assign b           = sym_valid & fifo_head.b;
  assign full        = fifo_full;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign hit_cnt     = hit_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ab_stim_tx.sv
// Directed bench for ab_stim_tx with a queue-based reference model checked every cycle.
module tb_ab_stim_tx;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int DRAIN   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, wr_a = 1'b0, wr_b = 1'b0;
  logic       go = 1'b0, sym_ready = 1'b0, y = 1'b0;
  logic       full, a, b, sym_valid, busy, done, err_timeout;
  logic [7:0] hit_cnt;

  int vectors = 0;
  int miscompares = 0;

  ab_stim_tx #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT),
    .DRAIN  (DRAIN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_a       (wr_a),
    .wr_b       (wr_b),
    .full       (full),
    .go         (go),
    .a          (a),
    .b          (b),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .y          (y),
    .busy       (busy),
    .done       (done),
    .hit_cnt    (hit_cnt),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 sending, 2 draining, 3 done.
  logic [1:0] m_q[$];
  int         m_ph = 0;
  int         m_drain_left = 0;
  int         m_stall = 0;
  int         m_hits = 0;
  bit         m_err = 1'b0;
  bit         m_push_ok, m_flush;
  int         m_nph;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ph    = 0;
      m_stall = 0;
      m_hits  = 0;
      m_err   = 1'b0;
    end else begin
      m_push_ok = wr_en && (m_q.size() < DEPTH);
      m_flush   = 1'b0;
      m_nph     = m_ph;
      if ((m_ph == 1 || m_ph == 2) && y && m_hits < 255) m_hits++;
      case (m_ph)
        0: if (go && m_q.size() > 0) begin
          m_nph = 1; m_hits = 0; m_err = 1'b0; m_stall = 0;
        end
        1: if (sym_ready) begin
          void'(m_q.pop_front());
          m_stall = 0;
          if (m_q.size() == 0 && !m_push_ok) begin
            m_nph = 2; m_drain_left = DRAIN;
          end
        end else begin
          m_stall++;
          if (m_stall == TIMEOUT) begin
            m_err = 1'b1; m_flush = 1'b1; m_nph = 3; m_stall = 0;
          end
        end
        2: begin
          m_drain_left--;
          if (m_drain_left == 0) m_nph = 3;
        end
        default: m_nph = 0;
      endcase
      if (m_flush) m_q.delete();
      else if (m_push_ok) m_q.push_back({wr_a, wr_b});
      m_ph = m_nph;
    end
  end

  logic [1:0] c_head;
  bit         c_sv;

  always @(negedge clk) begin
    c_sv   = (m_ph == 1);
    c_head = (c_sv && m_q.size() > 0) ? m_q[0] : 2'b00;
    chk("sym_valid", int'(sym_valid), int'(c_sv));
    chk("a", int'(a), int'(c_head[1]));
    chk("b", int'(b), int'(c_head[0]));
    chk("full", int'(full), int'(m_q.size() == DEPTH));
    chk("busy", int'(busy), int'(m_ph != 0));
    chk("done", int'(done), int'(m_ph == 3));
    chk("hit_cnt", int'(hit_cnt), m_hits);
    chk("err_timeout", int'(err_timeout), int'(m_err));
  end

  // Log what the recognizer actually consumed.
  logic [1:0] sent[$];
  int         valid_cycles = 0;
  always @(posedge clk) begin
    if (rst_n && sym_valid) begin
      valid_cycles++;
      if (sym_ready) sent.push_back({a, b});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic pa, input logic pb);
    wr_en = 1'b1; wr_a = pa; wr_b = pb;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 400) begin
      tick();
      cycles++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  logic [1:0] exp1[3] = '{2'b10, 2'b01, 2'b11};
  logic [1:0] exp2[4] = '{2'b00, 2'b11, 2'b01, 2'b10};
  logic [1:0] exp3[3] = '{2'b01, 2'b10, 2'b11};
  int         cyc;

  initial begin
    #3;
    chk("rst_sym_valid", int'(sym_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hit_cnt", int'(hit_cnt), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic three-symbol run
    sym_ready = 1'b1;
    push(1'b1, 1'b0); push(1'b0, 1'b1); push(1'b1, 1'b1);
    sent.delete(); valid_cycles = 0;
    start();
    chk("t1_valid_after_go", int'(sym_valid), 1);
    wait_done(cyc);
    chk("t1_run_len", cyc + 1, 6);
    chk("t1_valid_cycles", valid_cycles, 3);
    chk("t1_sent_n", sent.size(), 3);
    for (int i = 0; i < 3 && i < sent.size(); i++) chk("t1_sym", int'(sent[i]), int'(exp1[i]));
    tick();
    chk("t1_busy_low", int'(busy), 0);
    chk("t1_done_low", int'(done), 0);

    // Overfill: fifth push dropped
    push(1'b0, 1'b0); push(1'b1, 1'b1); push(1'b0, 1'b1);
    chk("t2_not_full", int'(full), 0);
    push(1'b1, 1'b0);
    chk("t2_full", int'(full), 1);
    push(1'b1, 1'b1);
    sent.delete();
    start();
    wait_done(cyc);
    chk("t2_sent_n", sent.size(), 4);
    for (int i = 0; i < 4 && i < sent.size(); i++) chk("t2_sym", int'(sent[i]), int'(exp2[i]));
    tick();

    // Three-cycle stall mid-stream
    push(1'b0, 1'b1); push(1'b1, 1'b0); push(1'b1, 1'b1);
    sent.delete();
    start();
    tick();
    sym_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_valid", int'(sym_valid), 1);
      chk("t3_stall_a", int'(a), 1);
      chk("t3_stall_b", int'(b), 0);
      tick();
    end
    sym_ready = 1'b1;
    wait_done(cyc);
    chk("t3_sent_n", sent.size(), 3);
    for (int i = 0; i < 3 && i < sent.size(); i++) chk("t3_sym", int'(sent[i]), int'(exp3[i]));
    chk("t3_no_timeout", int'(err_timeout), 0);
    tick();

    // Timeout abort after one hit
    push(1'b1, 1'b0); push(1'b0, 1'b1); push(1'b1, 1'b1);
    start();
    y = 1'b1;
    tick();
    y = 1'b0; sym_ready = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) tick();
    chk("t4_done", int'(done), 1);
    chk("t4_err", int'(err_timeout), 1);
    chk("t4_hits_kept", int'(hit_cnt), 1);
    tick();
    chk("t4_idle", int'(busy), 0);
    start();
    chk("t4_go_empty_ignored", int'(busy), 0);
    chk("t4_err_sticky", int'(err_timeout), 1);
    sym_ready = 1'b1;
    push(1'b1, 1'b1);
    start();
    chk("t4_err_cleared", int'(err_timeout), 0);
    wait_done(cyc);
    tick();

    // Hits on two SEND cycles and one DRAIN cycle
    push(1'b0, 1'b1); push(1'b1, 1'b0);
    start();
    y = 1'b1;
    tick(); tick(); tick();
    y = 1'b0;
    tick();
    chk("t5_done", int'(done), 1);
    chk("t5_hits", int'(hit_cnt), 3);
    tick();

    // Saturate the hit counter with a long refilled run
    push(1'b1, 1'b0);
    start();
    wr_en = 1'b1; y = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wr_a = i[0]; wr_b = i[1];
      tick();
    end
    wr_en = 1'b0;
    wait_done(cyc);
    chk("t5_saturated", int'(hit_cnt), 255);
    y = 1'b0;
    tick();
    chk("t5_hold_idle", int'(hit_cnt), 255);

    // Asynchronous reset mid-SEND
    sym_ready = 1'b0;
    push(1'b1, 1'b1); push(1'b1, 1'b0); push(1'b0, 1'b1);
    start();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(sym_valid), 0);
    chk("t6_rst_a", int'(a), 0);
    chk("t6_rst_b", int'(b), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_full", int'(full), 0);
    chk("t6_rst_hits", int'(hit_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();
    start();
    chk("t6_go_empty_busy", int'(busy), 0);
    chk("t6_go_empty_valid", int'(sym_valid), 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ab_stim_tx.md
# ab_stim_tx

Sequential symbol transmitter that drives the `a`/`b` inputs of the two-input sequence-recognizer FSM and counts the `y` detections it returns. It sits on the sending side of the recognizer's interface. Symbols are buffered in a small FIFO, streamed one per accepted cycle under a valid/ready handshake, and followed by a short drain window so the recognizer's final `y` is captured. It replaces hand-written stimulus with a reusable, self-checking source.

## Interface
- `DEPTH`, default 4: FIFO depth in symbols; must be a power of 2, minimum 2.
- `TIMEOUT`, default 8: consecutive stalled SEND cycles before abort; range 1..255.
- `DRAIN`, default 2: cycles spent in DRAIN after the last accepted symbol; minimum 1.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push one symbol into the FIFO.
- `wr_a` in 1: `a` value of the pushed symbol.
- `wr_b` in 1: `b` value of the pushed symbol.
- `full` out 1: FIFO holds DEPTH symbols.
- `go` in 1: start transmission; sampled only in IDLE.
- `a` out 1: symbol `a` driven to the recognizer.
- `b` out 1: symbol `b` driven to the recognizer.
- `sym_valid` out 1: `a`/`b` hold a valid symbol.
- `sym_ready` in 1: recognizer consumes the symbol this cycle.
- `y` in 1: recognizer detection output.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when a run finishes.
- `hit_cnt` out 8: number of `y` detections in the current run; saturates at 255.
- `err_timeout` out 1: sticky flag set when a run is aborted by timeout.

## Operation
- Reset values: `a`=0, `b`=0, `sym_valid`=0, `full`=0, `busy`=0, `done`=0, `hit_cnt`=0, `err_timeout`=0. FIFO is empty and state is IDLE.
- FIFO behaviour:
  - A push is accepted iff `wr_en` is high and `full` is low, judged at the start of the cycle.
  - If the FIFO is full, a push is dropped even if a pop happens in the same cycle.
  - Pushes are legal in every state.
- States:
  - IDLE: on `go` with the FIFO non-empty, go to SEND, clear `hit_cnt` and `err_timeout`. If `go` arrives with the FIFO empty, stay in IDLE with no effect.
  - SEND: `sym_valid`=1. `a`/`b` equal the FIFO head. On `sym_valid & sym_ready`, pop. If that pop empties the FIFO (and no push lands in the same cycle), go to DRAIN. Otherwise stay in SEND.
  - DRAIN: lasts DRAIN cycles with `sym_valid`=0, then go to DONE. Symbols pushed during DRAIN are kept for the next run.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Stall counter:
  - Counts consecutive SEND cycles with `sym_ready` low.
  - Resets to 0 on any handshake.
  - When it reaches TIMEOUT: set `err_timeout`, flush the FIFO, go to DONE.
- Hit counting: `hit_cnt` increments on every cycle in SEND or DRAIN where `y`=1, saturating at 255. It holds its value through IDLE until the next `go` is accepted.
- Outputs when `sym_valid`=0: `a` and `b` are driven to 0.
- `go` while `busy`=1 is ignored.

## Timing
- `go` is sampled at edge k, so `sym_valid` is high during cycle k+1.
- Back-to-back throughput is 1 symbol per cycle while `sym_ready`=1.
- `a`, `b` and `sym_valid` are decoded from registered state and FIFO storage only. There is no combinational path from `sym_ready` or `y` to any output.
- Run length from `go` to the `done` pulse is (N symbols) + (stall cycles) + DRAIN + 1 cycles.
- A push in the same cycle as the final pop keeps the run in SEND.
- Asserting `rst_n` low mid-run returns every output to its reset value immediately, without waiting for a clock edge, and discards FIFO contents.

## Structure
- Shared package `ab_tx_pkg`:
  - state enum `ab_tx_state_t` with IDLE, SEND, DRAIN, DONE;
  - packed struct `ab_sym_t` with fields a and b;
  - constant `HIT_MAX`=255.
- Sub-module `ab_sym_fifo`: DEPTH-deep FIFO of `ab_sym_t`, with `clk` and `rst_n` ports, push/pop inputs, and full/empty/head outputs. Pointers are one bit wider than the index to separate full from empty.
- Top level: FSM, stall counter, drain counter and hit counter.

## Test plan
- Push (a=1,b=0),(a=0,b=1),(a=1,b=1) with `sym_ready`=1, then `go` → `sym_valid` high for exactly 3 consecutive cycles with a/b in push order. Then 2 DRAIN cycles, then `done` for 1 cycle, `busy` low.
- Push 5 symbols with DEPTH=4 → `full`=1 after the 4th push, the 5th push is dropped, and only 4 symbols are sent.
- Hold `sym_ready`=0 for 3 cycles mid-stream → `a`/`b`/`sym_valid` remain stable throughout the stall, no symbol is lost or duplicated, and `err_timeout`=0.
- Hold `sym_ready`=0 for 8 cycles → `err_timeout`=1, FIFO empty, `done` pulses, `hit_cnt` keeps the hits recorded before the abort. The next `go` clears `err_timeout`.
- Drive `y`=1 on 2 SEND cycles and 1 DRAIN cycle → `hit_cnt`=3 at `done`. Force 300 hits → `hit_cnt`=255.
- Drop `rst_n` mid-SEND → all outputs read 0 before the next clock edge, state is IDLE, and a `go` issued afterwards with the FIFO empty has no effect.
